// File: rtl/ps2_key_controller.sv
// PS/2 keyboard receiver: filtered ps2Clk, framed byte capture with parity/stop/timeout
// checks, E0/F0 prefix tracking and WASD/arrow held-key flags.
//
// Frame FSM
//   state   | meaning
//   IDLE    | waiting for a start bit (data=0 on a filtered falling edge)
//   DATA    | shifting in 8 data bits, LSB first
//   PARITY  | capturing the odd-parity bit
//   STOP    | capturing the stop bit, judging the frame
// Decode FSM
//   state   | meaning
//   NORMAL  | no prefix pending
//   EXT     | E0 seen, next code is extended
//   BRK     | F0 seen, next code is a release
//   EXT_BRK | E0 F0 seen, next code is an extended release
module ps2_key_controller #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clock50,
  input  logic       reset_n,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       is_break,
  output logic       is_ext,
  output logic       frame_err,
  output logic       w_pressed,
  output logic       a_pressed,
  output logic       s_pressed,
  output logic       d_pressed,
  output logic [3:0] bitcount
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
  typedef enum logic [1:0] {NORMAL, EXT, BRK, EXT_BRK} dec_state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall_edge;
  logic          data_s;

  frame_state_t  frame_state;
  logic [TW-1:0] timeout_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic          stop_edge;
  logic          frame_good;
  logic          timed_out;

  dec_state_t    dec_state;
  logic          ev_brk;
  logic          ev_ext;
  logic          hit_w;
  logic          hit_a;
  logic          hit_s;
  logic          hit_d;

  assign data_s = data_sync[1];

  // Synchronizers idle high so reset release never looks like a falling edge.
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_filt  <= 1'b1;
      filt_cnt  <= '0;
      fall_edge <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2Clk};
      data_sync <= {data_sync[0], ps2Data};
      fall_edge <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_MAX) begin
        clk_filt  <= clk_sync[1];
        filt_cnt  <= '0;
        fall_edge <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign stop_edge  = (frame_state == STOP) && fall_edge;
  assign frame_good = stop_edge && data_s && (^{shift_reg, parity_bit});
  assign timed_out  = (frame_state != IDLE) && !fall_edge && (timeout_cnt == TO_MAX);

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      frame_state <= IDLE;
      timeout_cnt <= '0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      bitcount    <= '0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= (stop_edge && !frame_good) || timed_out;

      if (frame_state == IDLE || fall_edge)
        timeout_cnt <= '0;
      else
        timeout_cnt <= timeout_cnt + TW'(1);

      if (timed_out) begin
        frame_state <= IDLE;
        bitcount    <= '0;
      end else if (fall_edge) begin
        case (frame_state)
          IDLE: begin
            if (!data_s) begin
              frame_state <= DATA;
              bitcount    <= 4'd1;
            end
          end
          DATA: begin
            shift_reg <= {data_s, shift_reg[7:1]};
            bitcount  <= bitcount + 4'd1;
            if (bitcount == 4'd8)
              frame_state <= PARITY;
          end
          PARITY: begin
            parity_bit  <= data_s;
            bitcount    <= bitcount + 4'd1;
            frame_state <= STOP;
          end
          STOP: begin
            frame_state <= IDLE;
            bitcount    <= '0;
          end
          default: begin
            frame_state <= IDLE;
            bitcount    <= '0;
          end
        endcase
      end
    end
  end

  assign ev_brk = (dec_state == BRK) || (dec_state == EXT_BRK);
  assign ev_ext = (dec_state == EXT) || (dec_state == EXT_BRK);
  assign hit_w  = ev_ext ? (shift_reg == 8'h75) : (shift_reg == 8'h1D);
  assign hit_a  = ev_ext ? (shift_reg == 8'h6B) : (shift_reg == 8'h1C);
  assign hit_s  = ev_ext ? (shift_reg == 8'h72) : (shift_reg == 8'h1B);
  assign hit_d  = ev_ext ? (shift_reg == 8'h74) : (shift_reg == 8'h23);

  // Decoding sees the byte in the stop-edge cycle so events land exactly one cycle later.
  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      dec_state  <= NORMAL;
      code       <= '0;
      code_valid <= 1'b0;
      is_break   <= 1'b0;
      is_ext     <= 1'b0;
      w_pressed  <= 1'b0;
      a_pressed  <= 1'b0;
      s_pressed  <= 1'b0;
      d_pressed  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      is_break   <= 1'b0;
      is_ext     <= 1'b0;
      if (frame_good) begin
        if (shift_reg == 8'hE0) begin
          if (dec_state == NORMAL)
            dec_state <= EXT;
        end else if (shift_reg == 8'hF0) begin
          if (dec_state == NORMAL)
            dec_state <= BRK;
          else if (dec_state == EXT)
            dec_state <= EXT_BRK;
        end else begin
          code       <= shift_reg;
          code_valid <= 1'b1;
          is_break   <= ev_brk;
          is_ext     <= ev_ext;
          dec_state  <= NORMAL;
          if (hit_w) w_pressed <= !ev_brk;
          if (hit_a) a_pressed <= !ev_brk;
          if (hit_s) s_pressed <= !ev_brk;
          if (hit_d) d_pressed <= !ev_brk;
        end
      end
    end
  end

endmodule
